// File: rtl/sd_host_platform_cocotb.sv
// -----------------------------------------------------------------------------
// sd_host_platform_cocotb
//
// Host-side SD physical layer for the cocotb simulation platform. Divides the
// system clock down to the SD bus clock, launches CMD on the SD falling edge
// and samples it on the rising edge, and moves bytes over the 4-bit DATA bus
// as DDR nibble pairs (high nibble while the SD clock is high, low nibble
// while it is low).
//
// Ports:
//   clk             system clock, rising-edge active
//   rst             asynchronous reset, active-low
//   i_clk_en        1 = run the SD clock, 0 = park it low at the next boundary
//   i_clk_div       SD clock half-period in clk cycles, minus 1
//   o_locked        platform ready, LOCK_COUNT+1 cycles after reset release
//   o_posedge_stb   pulse in the first cycle o_phy_clk is high
//   o_negedge_stb   pulse in the first cycle o_phy_clk is low
//   i_sd_cmd_dir    1 = host drives CMD
//   i_sd_cmd_out    CMD bit to launch
//   o_sd_cmd_in     CMD bit sampled at the SD rising edge
//   i_sd_data_dir   1 = host drives DATA
//   i_sd_data_out   byte to transmit
//   o_sd_data_in    received byte
//   o_sd_data_stb   pulse when o_sd_data_in updates
//   o_phy_clk       SD bus clock
//   io_phy_sd_cmd   SD CMD pin
//   io_phy_sd_data  SD DATA pins
// -----------------------------------------------------------------------------
module sd_host_platform_cocotb #(
  parameter int DIV_WIDTH  = 8,
  parameter int LOCK_COUNT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clk_en,
  input  logic [DIV_WIDTH-1:0] i_clk_div,
  output logic                 o_locked,
  output logic                 o_posedge_stb,
  output logic                 o_negedge_stb,
  input  logic                 i_sd_cmd_dir,
  input  logic                 i_sd_cmd_out,
  output logic                 o_sd_cmd_in,
  input  logic                 i_sd_data_dir,
  input  logic [7:0]           i_sd_data_out,
  output logic [7:0]           o_sd_data_in,
  output logic                 o_sd_data_stb,
  output logic                 o_phy_clk,
  inout  wire                  io_phy_sd_cmd,
  inout  wire  [3:0]           io_phy_sd_data
);

  localparam int LOCK_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] div_q, div_n;
  logic                 rise, fall;

  logic [LOCK_W-1:0]    lock_cnt;
  logic                 cmd_q;     // CMD launch register
  logic [3:0]           tx_nib;    // nibble currently on DATA
  logic [3:0]           tx_low;    // low nibble held from the R-edge
  logic [3:0]           rx_hi;     // high nibble captured at the F-edge

  // ---------------------------------------------------------------------------
  // Lock counter: saturates at LOCK_COUNT; o_locked follows one cycle later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_cnt <= '0;
      o_locked <= 1'b0;
    end else begin
      if (lock_cnt != LOCK_W'(LOCK_COUNT)) lock_cnt <= lock_cnt + 1'b1;
      o_locked <= (lock_cnt == LOCK_W'(LOCK_COUNT)) | o_locked;
    end
  end

  // ---------------------------------------------------------------------------
  // Clock FSM next-state logic. rise/fall mark the clk edge that will make
  // o_phy_clk go high/low; every other datapath register keys off them.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_q;
    rise    = 1'b0;
    fall    = 1'b0;
    case (state)
      IDLE: begin
        if (i_clk_en) begin
          rise    = 1'b1;
          cnt_n   = '0;
          div_n   = i_clk_div;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt != div_q) begin
          cnt_n = cnt + 1'b1;
        end else begin
          // Phase boundary: the only point where the divider may change.
          cnt_n = '0;
          div_n = i_clk_div;
          if (o_phy_clk) begin
            // A high phase always completes with its falling edge.
            fall = 1'b1;
            if (!i_clk_en) state_n = IDLE;
          end else if (i_clk_en) begin
            rise = 1'b1;
          end else begin
            // Stopping while low: suppress the rising edge entirely.
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered state and datapath.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      div_q         <= '0;
      o_phy_clk     <= 1'b0;
      o_posedge_stb <= 1'b0;
      o_negedge_stb <= 1'b0;
      o_sd_data_stb <= 1'b0;
      o_sd_data_in  <= 8'h00;
      o_sd_cmd_in   <= 1'b1;
      cmd_q         <= 1'b1;
      tx_nib        <= 4'h0;
      tx_low        <= 4'h0;
      rx_hi         <= 4'h0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of the others (e.g. rx_hi is read before it updates).
      state         <= state_n;
      cnt           <= cnt_n;
      div_q         <= div_n;
      o_posedge_stb <= rise;
      o_negedge_stb <= fall;
      o_sd_data_stb <= rise;
      if (rise) begin
        o_phy_clk    <= 1'b1;
        tx_nib       <= i_sd_data_out[7:4];
        tx_low       <= i_sd_data_out[3:0];
        o_sd_data_in <= {rx_hi, io_phy_sd_data};
        o_sd_cmd_in  <= io_phy_sd_cmd;
      end
      if (fall) begin
        o_phy_clk <= 1'b0;
        tx_nib    <= tx_low;
        rx_hi     <= io_phy_sd_data;
        cmd_q     <= i_sd_cmd_out;
      end
    end
  end

  // Pin drivers: combinational on the direction inputs.
  assign io_phy_sd_cmd  = i_sd_cmd_dir  ? cmd_q  : 1'bz;
  assign io_phy_sd_data = i_sd_data_dir ? tx_nib : 4'hz;

endmodule

// File: tb/tb_sd_host_platform_cocotb.sv
// -----------------------------------------------------------------------------
// tb_sd_host_platform_cocotb
//
// Directed bench for sd_host_platform_cocotb. Each scenario task resets the
// DUT, drives its stimulus and compares outputs one time unit after the
// rising clk edge against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_sd_host_platform_cocotb;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_clk_en;
  logic [7:0] i_clk_div;
  logic       o_locked;
  logic       o_posedge_stb;
  logic       o_negedge_stb;
  logic       i_sd_cmd_dir;
  logic       i_sd_cmd_out;
  logic       o_sd_cmd_in;
  logic       i_sd_data_dir;
  logic [7:0] i_sd_data_out;
  logic [7:0] o_sd_data_in;
  logic       o_sd_data_stb;
  logic       o_phy_clk;
  wire        io_phy_sd_cmd;
  wire  [3:0] io_phy_sd_data;

  // Bench-side device model drivers on the shared pins.
  logic       tb_cmd_en;
  logic       tb_cmd;
  logic       tb_data_en;
  logic [3:0] tb_data;

  assign io_phy_sd_cmd  = tb_cmd_en  ? tb_cmd  : 1'bz;
  assign io_phy_sd_data = tb_data_en ? tb_data : 4'hz;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sd_host_platform_cocotb #(
    .DIV_WIDTH (8),
    .LOCK_COUNT(15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_clk_en      (i_clk_en),
    .i_clk_div     (i_clk_div),
    .o_locked      (o_locked),
    .o_posedge_stb (o_posedge_stb),
    .o_negedge_stb (o_negedge_stb),
    .i_sd_cmd_dir  (i_sd_cmd_dir),
    .i_sd_cmd_out  (i_sd_cmd_out),
    .o_sd_cmd_in   (o_sd_cmd_in),
    .i_sd_data_dir (i_sd_data_dir),
    .i_sd_data_out (i_sd_data_out),
    .o_sd_data_in  (o_sd_data_in),
    .o_sd_data_stb (o_sd_data_stb),
    .o_phy_clk     (o_phy_clk),
    .io_phy_sd_cmd (io_phy_sd_cmd),
    .io_phy_sd_data(io_phy_sd_data)
  );

  // Advance to just after the next rising clk edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Defaults on all inputs, 3 cycles of reset, release away from the edge.
  task automatic do_reset();
    i_clk_en      = 1'b0;
    i_clk_div     = 8'd0;
    i_sd_cmd_dir  = 1'b0;
    i_sd_cmd_out  = 1'b1;
    i_sd_data_dir = 1'b0;
    i_sd_data_out = 8'h00;
    tb_cmd_en     = 1'b0;
    tb_cmd        = 1'b1;
    tb_data_en    = 1'b0;
    tb_data       = 4'h0;
    rst           = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({o_phy_clk, o_posedge_stb, o_negedge_stb, o_sd_data_stb, o_locked} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000",
               {o_phy_clk, o_posedge_stb, o_negedge_stb, o_sd_data_stb, o_locked});
    else passed++;
    checks++;
    if (o_sd_data_in !== 8'h00 || o_sd_cmd_in !== 1'b1)
      $display("FAIL reset_data: data_in=%h cmd_in=%b want 00/1", o_sd_data_in, o_sd_cmd_in);
    else passed++;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (o_locked !== (k >= 16))
        $display("FAIL lock_cycle%0d: got %b want %b", k, o_locked, (k >= 16));
      else passed++;
      checks++;
      if (o_phy_clk !== 1'b0)
        $display("FAIL lock_phy_clk%0d: got %b want 0", k, o_phy_clk);
      else passed++;
    end
  endtask

  task automatic test_divider();
    do_reset();
    i_clk_div = 8'd3;
    i_clk_en  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (o_phy_clk !== ((i % 8) < 4))
        $display("FAIL div3_clk s%0d: got %b want %b", i, o_phy_clk, ((i % 8) < 4));
      else passed++;
      checks++;
      if (o_posedge_stb !== (i % 8 == 0) || o_negedge_stb !== (i % 8 == 4))
        $display("FAIL div3_stb s%0d: got pos=%b neg=%b want pos=%b neg=%b", i,
                 o_posedge_stb, o_negedge_stb, (i % 8 == 0), (i % 8 == 4));
      else passed++;
    end
    // Divider drops to 0 one cycle into this high phase.
    for (int j = 0; j < 8; j++) begin
      tick();
      checks++;
      if (o_phy_clk !== ((j < 4) ? 1'b1 : 1'(j % 2)))
        $display("FAIL div_change s%0d: got %b want %b", j, o_phy_clk,
                 ((j < 4) ? 1'b1 : 1'(j % 2)));
      else passed++;
      if (j == 0) i_clk_div = 8'd0;
    end
  endtask

  task automatic test_ddr_tx();
    logic [3:0] exp_nib [5] = '{4'hA, 4'hA, 4'h5, 4'h5, 4'h3};
    logic       exp_cmd [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    i_clk_div     = 8'd1;
    i_sd_cmd_dir  = 1'b1;
    i_sd_data_dir = 1'b1;
    i_sd_data_out = 8'hA5;
    i_sd_cmd_out  = 1'b0;
    i_clk_en      = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      // Next byte offered right after the R-edge; low nibble must stay 5.
      if (s == 0) i_sd_data_out = 8'h3C;
      checks++;
      if (io_phy_sd_data !== exp_nib[s])
        $display("FAIL tx_data s%0d: got %h want %h", s, io_phy_sd_data, exp_nib[s]);
      else passed++;
      checks++;
      if (io_phy_sd_cmd !== exp_cmd[s])
        $display("FAIL tx_cmd s%0d: got %b want %b", s, io_phy_sd_cmd, exp_cmd[s]);
      else passed++;
    end
  endtask

  task automatic test_ddr_rx();
    do_reset();
    tb_cmd_en  = 1'b1;
    tb_cmd     = 1'b1;
    tb_data_en = 1'b1;
    tb_data    = 4'h0;
    i_clk_div  = 8'd1;
    i_clk_en   = 1'b1;
    for (int s = 0; s < 6; s++) begin
      tick();
      checks++;
      if (o_sd_data_stb !== (s == 0 || s == 4))
        $display("FAIL rx_stb s%0d: got %b want %b", s, o_sd_data_stb, (s == 0 || s == 4));
      else passed++;
      if (s == 0) begin
        checks++;
        if (o_sd_data_in !== 8'h00 || o_sd_cmd_in !== 1'b1)
          $display("FAIL rx_first: data_in=%h cmd_in=%b want 00/1", o_sd_data_in, o_sd_cmd_in);
        else passed++;
        tb_data = 4'h3;
      end
      if (s == 2) begin
        tb_data = 4'hC;
        tb_cmd  = 1'b0;
      end
      if (s >= 4) begin
        checks++;
        if (o_sd_data_in !== 8'h3C || o_sd_cmd_in !== 1'b0)
          $display("FAIL rx_byte s%0d: data_in=%h cmd_in=%b want 3c/0", s,
                   o_sd_data_in, o_sd_cmd_in);
        else passed++;
      end
    end
  endtask

  task automatic test_clock_stop();
    do_reset();
    i_clk_div = 8'd2;
    i_clk_en  = 1'b1;
    tick();
    checks++;
    if (o_phy_clk !== 1'b1 || o_posedge_stb !== 1'b1)
      $display("FAIL stop_start: clk=%b pos=%b want 1/1", o_phy_clk, o_posedge_stb);
    else passed++;
    i_clk_en = 1'b0;
    for (int s = 1; s < 10; s++) begin
      tick();
      checks++;
      if (o_phy_clk !== (s < 3) || o_negedge_stb !== (s == 3) || o_posedge_stb !== 1'b0)
        $display("FAIL stop s%0d: clk=%b pos=%b neg=%b want %b/0/%b", s, o_phy_clk,
                 o_posedge_stb, o_negedge_stb, (s < 3), (s == 3));
      else passed++;
    end
    i_clk_en = 1'b1;
    tick();
    checks++;
    if (o_phy_clk !== 1'b1 || o_posedge_stb !== 1'b1)
      $display("FAIL restart: clk=%b pos=%b want 1/1", o_phy_clk, o_posedge_stb);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_clk_div     = 8'd3;
    i_sd_cmd_dir  = 1'b1;
    i_sd_data_dir = 1'b1;
    i_sd_data_out = 8'hA5;
    i_sd_cmd_out  = 1'b0;
    i_clk_en      = 1'b1;
    repeat (17) tick();
    // Third R-edge: DATA loops back, so the received byte is A5.
    checks++;
    if ({o_phy_clk, o_posedge_stb, o_sd_data_stb, o_locked, io_phy_sd_cmd} !== 5'b11110
        || o_sd_data_in !== 8'hA5)
      $display("FAIL mid_before: ctrl=%b data_in=%h want 11110/a5",
               {o_phy_clk, o_posedge_stb, o_sd_data_stb, o_locked, io_phy_sd_cmd},
               o_sd_data_in);
    else passed++;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({o_phy_clk, o_posedge_stb, o_negedge_stb, o_sd_data_stb, o_locked} !== 5'b0)
      $display("FAIL mid_ctrl: got %b want 00000",
               {o_phy_clk, o_posedge_stb, o_negedge_stb, o_sd_data_stb, o_locked});
    else passed++;
    checks++;
    if (o_sd_data_in !== 8'h00 || io_phy_sd_cmd !== 1'b1 || io_phy_sd_data !== 4'h0)
      $display("FAIL mid_data: data_in=%h cmd=%b data=%h want 00/1/0",
               o_sd_data_in, io_phy_sd_cmd, io_phy_sd_data);
    else passed++;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_divider();
    test_ddr_tx();
    test_ddr_rx();
    test_clock_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
